// File: rtl/tri_sched_if.sv
// Bundle of request, engine and pixel-stream signals around the triangle
// scheduler. The master modport is the scheduler itself; the slave modport
// is the side made of the requesters, the rasterizer engine and the pixel sink.
interface tri_sched_if;
  logic [1:0]  req_valid;
  logic [17:0] req_tri0;
  logic [17:0] req_tri1;
  logic [1:0]  req_ack;
  logic        nt;
  logic [2:0]  xi;
  logic [2:0]  yi;
  logic        busy;
  logic        po;
  logic [2:0]  xo;
  logic [2:0]  yo;
  logic        pix_valid;
  logic [2:0]  pix_x;
  logic [2:0]  pix_y;
  logic        pix_id;
  logic        done;
  logic [6:0]  done_cnt;
  logic        err;

  modport master (
    input  req_valid, req_tri0, req_tri1, busy, po, xo, yo,
    output req_ack, nt, xi, yi, pix_valid, pix_x, pix_y, pix_id,
           done, done_cnt, err
  );

  modport slave (
    output req_valid, req_tri0, req_tri1, busy, po, xo, yo,
    input  req_ack, nt, xi, yi, pix_valid, pix_x, pix_y, pix_id,
           done, done_cnt, err
  );
endinterface

// File: rtl/tri_sched.sv
// tri_sched: round-robin scheduler that feeds one of two requesters'
// triangles to a rasterizer engine, forwards the engine's pixels tagged with
// the owner, and reports a saturating per-triangle pixel count.
// Optional feature: define TRI_SCHED_TIMEOUT_EN to add an 8-bit RUN
// watchdog that forces completion after 255 RUN cycles and raises a sticky err.
module tri_sched (
  input  logic        clk,
  input  logic        reset,   // asynchronous, active-low
  tri_sched_if.master bus
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_FEED1 = 3'd1;
  localparam logic [2:0] S_FEED2 = 3'd2;
  localparam logic [2:0] S_FEED3 = 3'd3;
  localparam logic [2:0] S_RUN   = 3'd4;
  localparam logic [2:0] S_DRAIN = 3'd5;
  localparam logic [2:0] S_DONE  = 3'd6;

  localparam logic [6:0] CNT_MAX = 7'd127;

  logic [2:0]  state_q,     state_d;
  logic        last_q,      last_d;      // requester granted most recently
  logic        owner_q,     owner_d;     // owner of the triangle in flight
  logic [17:0] tri_q,       tri_d;
  logic [1:0]  ack_q,       ack_d;
  logic [6:0]  cnt_q,       cnt_d;
  logic [6:0]  done_cnt_q,  done_cnt_d;
  logic        pix_valid_q, pix_valid_d;
  logic [2:0]  pix_x_q,     pix_x_d;
  logic [2:0]  pix_y_q,     pix_y_d;
  logic        pix_id_q,    pix_id_d;
`ifdef TRI_SCHED_TIMEOUT_EN
  logic [7:0]  wdog_q,      wdog_d;
  logic        err_q,       err_d;
`endif

  logic        grant;
  logic        fwd;
  logic [2:0]  vx;
  logic [2:0]  vy;

  // Next-state logic: arbitration, sequencing, pixel capture and counting.
  always_comb begin
    // NOTE: every combinationally assigned signal gets a default first so no
    // path leaves it unassigned, which would infer a latch.
    state_d     = state_q;
    last_d      = last_q;
    owner_d     = owner_q;
    tri_d       = tri_q;
    ack_d       = 2'b00;
    cnt_d       = cnt_q;
    done_cnt_d  = done_cnt_q;
    pix_valid_d = 1'b0;
    pix_x_d     = pix_x_q;
    pix_y_d     = pix_y_q;
    pix_id_d    = pix_id_q;
`ifdef TRI_SCHED_TIMEOUT_EN
    wdog_d      = wdog_q;
    err_d       = err_q;
`endif

    // With both requesting, favour the one not served last; otherwise the
    // single active requester wins.
    grant = (bus.req_valid == 2'b11) ? ~last_q : bus.req_valid[1];

    // Pixels are accepted only while the engine owns the triangle.
    fwd = ((state_q == S_RUN) || (state_q == S_DRAIN)) && bus.po;
    if (fwd) begin
      pix_valid_d = 1'b1;
      pix_x_d     = bus.xo;
      pix_y_d     = bus.yo;
      pix_id_d    = owner_q;
      if (cnt_q != CNT_MAX) cnt_d = cnt_q + 7'd1;
    end

    case (state_q)
      S_IDLE: begin
        if (bus.req_valid != 2'b00) begin
          state_d = S_FEED1;
          last_d  = grant;
          owner_d = grant;
          tri_d   = grant ? bus.req_tri1 : bus.req_tri0;
          ack_d   = grant ? 2'b10 : 2'b01;
        end
      end
      S_FEED1: begin
        cnt_d   = 7'd0;
        state_d = S_FEED2;
      end
      S_FEED2: state_d = S_FEED3;
      S_FEED3: begin
        state_d = S_RUN;
`ifdef TRI_SCHED_TIMEOUT_EN
        wdog_d  = 8'd0;
`endif
      end
      S_RUN: begin
        if (!bus.busy) begin
          state_d = S_DRAIN;
        end
`ifdef TRI_SCHED_TIMEOUT_EN
        else begin
          wdog_d = wdog_q + 8'd1;
          // This RUN cycle brings the watchdog to 255: give up on the engine.
          if (wdog_q == 8'd254) begin
            state_d    = S_DONE;
            done_cnt_d = cnt_d;
            err_d      = 1'b1;
          end
        end
`endif
      end
      S_DRAIN: begin
        // cnt_d already includes a pixel captured in this last cycle.
        state_d    = S_DONE;
        done_cnt_d = cnt_d;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or negedge reset) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    if (!reset) begin
      state_q     <= S_IDLE;
      last_q      <= 1'b1;
      owner_q     <= 1'b0;
      tri_q       <= '0;
      ack_q       <= 2'b00;
      cnt_q       <= 7'd0;
      done_cnt_q  <= 7'd0;
      pix_valid_q <= 1'b0;
      pix_x_q     <= 3'd0;
      pix_y_q     <= 3'd0;
      pix_id_q    <= 1'b0;
`ifdef TRI_SCHED_TIMEOUT_EN
      wdog_q      <= 8'd0;
      err_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      last_q      <= last_d;
      owner_q     <= owner_d;
      tri_q       <= tri_d;
      ack_q       <= ack_d;
      cnt_q       <= cnt_d;
      done_cnt_q  <= done_cnt_d;
      pix_valid_q <= pix_valid_d;
      pix_x_q     <= pix_x_d;
      pix_y_q     <= pix_y_d;
      pix_id_q    <= pix_id_d;
`ifdef TRI_SCHED_TIMEOUT_EN
      wdog_q      <= wdog_d;
      err_q       <= err_d;
`endif
    end
  end

  // Vertex presented to the engine during the three feed cycles, zero otherwise.
  always_comb begin
    vx = 3'd0;
    vy = 3'd0;
    case (state_q)
      S_FEED1: begin vx = tri_q[17:15]; vy = tri_q[14:12]; end
      S_FEED2: begin vx = tri_q[11:9];  vy = tri_q[8:6];   end
      S_FEED3: begin vx = tri_q[5:3];   vy = tri_q[2:0];   end
      default: begin vx = 3'd0;         vy = 3'd0;         end
    endcase
  end

  assign bus.nt        = (state_q == S_FEED1);
  assign bus.xi        = vx;
  assign bus.yi        = vy;
  assign bus.req_ack   = ack_q;
  assign bus.pix_valid = pix_valid_q;
  assign bus.pix_x     = pix_x_q;
  assign bus.pix_y     = pix_y_q;
  assign bus.pix_id    = pix_id_q;
  assign bus.done      = (state_q == S_DONE);
  assign bus.done_cnt  = done_cnt_q;
`ifdef TRI_SCHED_TIMEOUT_EN
  assign bus.err       = err_q;
`else
  assign bus.err       = 1'b0;
`endif

endmodule

// File: tb/tb_tri_sched.sv
// Bench for tri_sched: a random engine/requester environment, a
// transaction-level reference model, a per-cycle compare process, and a few
// directed scenarios with hand-computed literal expectations.
module tb_tri_sched;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  tri_sched_if bus ();

  tri_sched dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // ---------------- environment controls ----------------
  bit          auto_req  = 1'b0;
  logic [1:0]  dir_valid = 2'b00;
  logic [17:0] dir_tri0  = '0;
  logic [17:0] dir_tri1  = '0;
  bit          eng_fixed = 1'b0;
  int          eng_len   = 8;
  bit          po_all    = 1'b0;
  int          eng_left  = 0;

  // Single driver of all DUT inputs; changes land on the falling edge.
  initial begin
    bus.req_valid = 2'b00;
    bus.req_tri0  = '0;
    bus.req_tri1  = '0;
    bus.busy      = 1'b0;
    bus.po        = 1'b0;
    bus.xo        = 3'd0;
    bus.yo        = 3'd0;
    forever begin
      @(negedge clk);
      // Engine: a new-triangle strobe starts a busy burst.
      if (!reset) eng_left = 0;
      else if (bus.nt) eng_left = eng_fixed ? eng_len : int'($urandom_range(3, 14));
      if (eng_left > 0) begin
        bus.busy = 1'b1;
        eng_left--;
      end else begin
        bus.busy = 1'b0;
      end
      bus.po = po_all ? 1'b1 : 1'($urandom_range(0, 1));
      bus.xo = 3'($urandom);
      bus.yo = 3'($urandom);
      // Requesters: hold a request until acked; triangle data churns freely.
      if (auto_req) begin
        for (int i = 0; i < 2; i++) begin
          if (bus.req_ack[i]) bus.req_valid[i] = 1'b0;
          else if (!bus.req_valid[i] && $urandom_range(0, 2) == 0) bus.req_valid[i] = 1'b1;
        end
        bus.req_tri0 = 18'($urandom);
        bus.req_tri1 = 18'($urandom);
      end else begin
        bus.req_valid = dir_valid;
        bus.req_tri0  = dir_tri0;
        bus.req_tri1  = dir_tri1;
      end
    end
  end

  // ---------------- reference model ----------------
  // A triangle's life is described by its age since the grant: ages 0..2
  // present the three vertices, then the engine runs until it reports idle;
  // the scheduler then needs one drain cycle and one completion cycle.
  bit          m_act   = 1'b0;   // a triangle is in flight
  int          m_age   = 0;      // cycles since FEED1, saturating at 3
  int          m_tail  = 0;      // 0 running, 1 drain cycle, 2 completion cycle
  int          m_run   = 0;      // busy cycles seen while running
  bit          m_last  = 1'b1;
  bit          m_owner = 1'b0;
  logic [17:0] m_tri   = '0;
  int          m_cnt   = 0;
  logic [1:0]  e_ack   = 2'b00;
  bit          e_pv    = 1'b0;
  logic [2:0]  e_px    = 3'd0;
  logic [2:0]  e_py    = 3'd0;
  bit          e_pid   = 1'b0;
  logic [6:0]  e_dcnt  = 7'd0;
  bit          e_err   = 1'b0;

  task automatic model_reset();
    m_act = 1'b0; m_age = 0; m_tail = 0; m_run = 0; m_last = 1'b1; m_owner = 1'b0;
    m_tri = '0; m_cnt = 0; e_ack = 2'b00; e_pv = 1'b0; e_px = 3'd0; e_py = 3'd0;
    e_pid = 1'b0; e_dcnt = 7'd0; e_err = 1'b0;
  endtask

  task automatic model_step();
    bit pick;
    bit window;
    window = m_act && (m_age >= 3) && (m_tail < 2);
    e_pv = 1'b0;
    if (window && bus.po) begin
      e_pv  = 1'b1;
      e_px  = bus.xo;
      e_py  = bus.yo;
      e_pid = m_owner;
      if (m_cnt < 127) m_cnt++;
    end
    e_ack = 2'b00;
    if (!m_act) begin
      if (bus.req_valid != 2'b00) begin
        pick    = (bus.req_valid == 2'b11) ? !m_last : bus.req_valid[1];
        m_last  = pick;
        m_owner = pick;
        m_tri   = pick ? bus.req_tri1 : bus.req_tri0;
        e_ack   = pick ? 2'b10 : 2'b01;
        m_act   = 1'b1; m_age = 0; m_tail = 0; m_run = 0; m_cnt = 0;
      end
    end else if (m_tail == 2) begin
      m_act = 1'b0;
    end else if (m_tail == 1) begin
      m_tail = 2;
      e_dcnt = 7'(m_cnt);
    end else if (m_age < 3) begin
      m_age++;
    end else if (!bus.busy) begin
      m_tail = 1;
    end else begin
      m_run++;
`ifdef TRI_SCHED_TIMEOUT_EN
      if (m_run == 255) begin
        m_tail = 2;
        e_dcnt = 7'(m_cnt);
        e_err  = 1'b1;
      end
`endif
    end
  endtask

  initial forever begin
    @(posedge clk or negedge reset);
    if (!reset) model_reset();
    else model_step();
  end

  // ---------------- compare process ----------------
  initial forever begin
    bit         exp_nt;
    logic [2:0] exp_xi;
    logic [2:0] exp_yi;
    @(negedge clk);
    #1;
    exp_nt = m_act && (m_age == 0);
    exp_xi = 3'd0;
    exp_yi = 3'd0;
    if (m_act && m_age < 3) begin
      exp_xi = m_tri[17 - 6*m_age -: 3];
      exp_yi = m_tri[14 - 6*m_age -: 3];
    end
    check("nt", bus.nt, exp_nt);
    check("xi", bus.xi, exp_xi);
    check("yi", bus.yi, exp_yi);
    check("req_ack", bus.req_ack, e_ack);
    check("pix_valid", bus.pix_valid, e_pv);
    if (e_pv) begin
      check("pix_x", bus.pix_x, e_px);
      check("pix_y", bus.pix_y, e_py);
      check("pix_id", bus.pix_id, e_pid);
    end
    check("done", bus.done, m_act && (m_tail == 2));
    check("done_cnt", bus.done_cnt, e_dcnt);
    check("err", bus.err, e_err);
  end

  // ---------------- directed helpers ----------------
  task automatic tick();
    @(negedge clk);
    #2;
  endtask

  task automatic wait_nt(input int lim);
    for (int i = 0; i < lim && !bus.nt; i++) tick();
    check("wait_nt", bus.nt, 1'b1);
  endtask

  task automatic wait_done(input int lim, output int cycles);
    cycles = 0;
    for (int i = 0; i < lim && !bus.done; i++) begin
      tick();
      cycles++;
    end
    check("wait_done", bus.done, 1'b1);
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 400 && m_act; i++) tick();
    check("wait_idle", m_act, 1'b0);
  endtask

  // Issue a one-shot request: visible on the bus for exactly one IDLE edge.
  task automatic request(input logic [1:0] v);
    dir_valid = v;
    tick();
    dir_valid = 2'b00;
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int cyc;
    int npix;
    int k;
    int g;
    #1 reset = 1'b0;
    repeat (3) tick();
    check("rst_nt", bus.nt, 1'b0);
    check("rst_ack", bus.req_ack, 2'b00);
    check("rst_pix_valid", bus.pix_valid, 1'b0);
    check("rst_done", bus.done, 1'b0);
    check("rst_done_cnt", bus.done_cnt, 7'd0);
    check("rst_err", bus.err, 1'b0);
    reset = 1'b1;
    tick();

    // Single request from requester 0, fixed engine, pixel every cycle.
    eng_fixed = 1'b1; eng_len = 8; po_all = 1'b1;
    dir_tri0  = 18'h00012;  // {0,0,0,0,2,2}
    dir_tri1  = 18'h3ffff;
    request(2'b01);
    tick();
    check("single_ack", bus.req_ack, 2'b01);
    check("single_nt1", bus.nt, 1'b1);
    check("single_v1", {bus.xi, bus.yi}, 6'o00);
    tick();
    check("single_nt2", bus.nt, 1'b0);
    check("single_v2", {bus.xi, bus.yi}, 6'o00);
    tick();
    check("single_v3", {bus.xi, bus.yi}, 6'o22);
    npix = 0;
    for (int i = 0; i < 50 && !bus.done; i++) begin
      tick();
      if (bus.pix_valid) npix++;
    end
    check("single_done", bus.done, 1'b1);
    check("single_done_cnt", bus.done_cnt, 7'd7);
    check("single_pix_count", npix, 7);
    check("drain_pix_valid", bus.pix_valid, 1'b1);
    check("drain_pix_id", bus.pix_id, 1'b0);
    wait_idle();

    // Back-to-back: requester 1 pends while requester 0's triangle runs.
    eng_len = 4; po_all = 1'b0;
    dir_valid = 2'b01;
    tick();
    dir_valid = 2'b10;
    wait_done(60, cyc);
    k = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      k++;
      if (bus.nt) break;
    end
    check("b2b_gap", k, 2);
    check("b2b_ack", bus.req_ack, 2'b10);
    dir_valid = 2'b00;
    wait_idle();

    // Saturation: 139 pixels offered, count sticks at 127.
    eng_len = 140; po_all = 1'b1;
    request(2'b01);
    wait_done(400, cyc);
    check("sat_done_cnt", bus.done_cnt, 7'd127);
    wait_idle();

    // Reset in the middle of RUN, then contention with both requests held.
    eng_len = 20; po_all = 1'b0;
    request(2'b01);
    wait_nt(10);
    repeat (4) tick();
    dir_valid = 2'b11;
    reset = 1'b0;
    #1;
    check("midrst_nt", bus.nt, 1'b0);
    check("midrst_xy", {bus.xi, bus.yi}, 6'o00);
    check("midrst_ack", bus.req_ack, 2'b00);
    check("midrst_pix_valid", bus.pix_valid, 1'b0);
    check("midrst_done", bus.done, 1'b0);
    check("midrst_done_cnt", bus.done_cnt, 7'd0);
    tick();
    reset = 1'b1;
    eng_fixed = 1'b0;
    for (g = 0; g < 4; g++) begin
      for (int i = 0; i < 100 && bus.req_ack == 2'b00; i++) tick();
      check("rr_grant", bus.req_ack, (g % 2 == 0) ? 2'b01 : 2'b10);
      tick();
    end
    dir_valid = 2'b00;
    wait_idle();

    // Random traffic.
    auto_req = 1'b1;
    repeat (1500) tick();
    auto_req = 1'b0;
    wait_idle();

`ifdef TRI_SCHED_TIMEOUT_EN
    // Engine never finishes: watchdog ends the triangle after 255 RUN cycles.
    eng_fixed = 1'b1; eng_len = 300;
    request(2'b01);
    wait_nt(10);
    wait_done(400, cyc);
    check("wdog_latency", cyc, 258);
    check("wdog_err", bus.err, 1'b1);
    eng_len = 6;
    request(2'b10);
    wait_done(60, cyc);
    check("wdog_err_sticky", bus.err, 1'b1);
    wait_idle();
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
